fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the control decoder. Holds the PC and

---
 rtl/fetch_unit.sv | 89 ++++++++
 tb/tb_fetch_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC holder and variable-latency instruction fetcher feeding control decode.
// Define FETCH_ALIGN_CHECK_EN to fault on a misaligned pc_next instead of silently aligning it.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        advance,
    input  logic [31:0] pc_next,
    output logic        fetch_err
);
    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ERR} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: if (imem_gnt) begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: if (imem_rvalid) begin
                instr_d = imem_rdata;
                state_d = HOLD;
            end else if (MAX_WAIT != 0 && cnt_q == LAST) begin
                state_d = ERR;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            HOLD: if (advance) begin
`ifdef FETCH_ALIGN_CHECK_EN
                if (pc_next[1:0] != 2'b00) begin
                    state_d = ERR;
                end else begin
                    pc_d    = pc_next;
                    state_d = REQ;
                end
`else
                pc_d    = pc_next & ~32'd3;
                state_d = REQ;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0013;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == HOLD);
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign fetch_err   = (state_q == ERR);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a transaction-level reference model checked every cycle.
module tb_fetch_unit;
    localparam int MW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        advance = 1'b0;
    logic [31:0] pc_next = 32'h0;
    logic        fetch_err;

    fetch_unit #(.RESET_PC(32'h0), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .advance(advance), .pc_next(pc_next), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase of the current fetch transaction and what the core should see.
    localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_HOLD = 3, P_ERR = 4;
    int          phase = P_IDLE;
    int          waited = 0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_instr = 32'h13;
    bit          started = 0;

    always @(posedge clk) begin
        if (rst) begin
            phase = P_IDLE; m_pc = 32'h0; m_instr = 32'h13; waited = 0; started = 1;
        end else if (phase == P_IDLE) phase = P_REQ;
        else if (phase == P_REQ && imem_gnt) begin phase = P_WAIT; waited = 0; end
        else if (phase == P_WAIT) begin
            if (imem_rvalid) begin m_instr = imem_rdata; phase = P_HOLD; end
            else begin waited++; if (waited == MW) phase = P_ERR; end
        end else if (phase == P_HOLD && advance) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (pc_next % 4 != 0) phase = P_ERR;
            else begin m_pc = pc_next; phase = P_REQ; end
`else
            m_pc = pc_next - (pc_next % 4); phase = P_REQ;
`endif
        end
    end

    always @(negedge clk) if (started) begin
        chk("imem_req", {31'h0, imem_req}, {31'h0, phase == P_REQ});
        chk("imem_addr", imem_addr, m_pc);
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("instr_valid", {31'h0, instr_valid}, {31'h0, phase == P_HOLD});
        chk("fetch_err", {31'h0, fetch_err}, {31'h0, phase == P_ERR});
        chk("instr", instr, m_instr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic to_wait();
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        chk("t0_reset_instr", instr, 32'h13);
        chk("t0_reset_req", {31'h0, imem_req}, 32'h0);
        tick();
        to_wait();
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; tick(); imem_rvalid = 1'b0;
        chk("t1_valid", {31'h0, instr_valid}, 32'h1);
        chk("t1_instr", instr, 32'h0050_0093);
        chk("t1_pc", pc, 32'h0);
        chk("t1_pc4", pc_plus4, 32'h4);

        advance = 1'b1; pc_next = 32'h40; tick(); advance = 1'b0;
        chk("t2_req", {31'h0, imem_req}, 32'h1);
        chk("t2_addr", imem_addr, 32'h40);
        chk("t2_valid", {31'h0, instr_valid}, 32'h0);

        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
        for (int i = 0; i < 3; i++) begin
            chk("t3_req_stall", {31'h0, imem_req}, 32'h1);
            chk("t3_addr_stall", imem_addr, 32'h40);
            tick();
        end
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0; imem_rvalid = 1'b0;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111; tick();
        imem_rdata = 32'hDEAD_BEEF; tick(); imem_rvalid = 1'b0;
        chk("t5_instr_held", instr, 32'h1111_1111);
        chk("t5_valid_held", {31'h0, instr_valid}, 32'h1);

        advance = 1'b1; pc_next = 32'hFFFF_FFFC; tick(); advance = 1'b0;
        to_wait();
        imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222; tick(); imem_rvalid = 1'b0;
        chk("t5_pc_wrap", pc, 32'hFFFF_FFFC);
        chk("t5_pc4_wrap", pc_plus4, 32'h0);

        advance = 1'b1; pc_next = 32'h102; tick(); advance = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("t6_align_err", {31'h0, fetch_err}, 32'h1);
        chk("t6_align_noreq", {31'h0, imem_req}, 32'h0);
`else
        chk("t6_align_addr", imem_addr, 32'h100);
        chk("t6_align_req", {31'h0, imem_req}, 32'h1);
`endif
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        tick();
        to_wait();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_rst_instr", instr, 32'h13);
        chk("t6_rst_valid", {31'h0, instr_valid}, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0002; tick(); tick(); imem_rvalid = 1'b0;
        chk("t6_stale_instr", instr, 32'h13);
        chk("t6_stale_req", {31'h0, imem_req}, 32'h1);

        to_wait();
        for (int i = 0; i < MW - 1; i++) tick();
        chk("t4_no_err_yet", {31'h0, fetch_err}, 32'h0);
        tick();
        chk("t4_timeout_err", {31'h0, fetch_err}, 32'h1);
        imem_gnt = 1'b1; imem_rvalid = 1'b1; advance = 1'b1;
        tick(); tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b0; advance = 1'b0;
        chk("t4_err_sticky", {31'h0, fetch_err}, 32'h1);
        chk("t4_err_noreq", {31'h0, imem_req}, 32'h0);

        rst = 1'b1; tick(); rst = 1'b0;
        tick();
        to_wait();
        for (int i = 0; i < MW - 1; i++) tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333; tick(); imem_rvalid = 1'b0;
        chk("t4_lastcycle_err", {31'h0, fetch_err}, 32'h0);
        chk("t4_lastcycle_instr", instr, 32'h3333_3333);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
